// File: rtl/spi_alu_pwm.sv
// Instruction executor behind the SPI slave: 4-bit ALU with a shift-add multiplier,
// plus a PWM generator whose duty is double-buffered to period boundaries.
module spi_alu_pwm #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PWM_DIV    = 1,
  parameter logic [7:0]  RESET_RESP = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [10:0] instr,
  output logic        instr_ready,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        busy,
  output logic        overrun,
  output logic        pwm_out
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_SET_DUTY, OP_SOFT_RESET
  } op_t;

  localparam int unsigned       PW        = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PWM_DIV - 1);

  state_t              state, state_nxt;
  op_t                 op;
  logic [3:0]          a, b;
  logic [1:0]          bit_idx;
  logic [7:0]          result, alu;
  logic [PWM_BITS-1:0] duty, duty_shadow, cnt;
  logic [PW-1:0]       presc;
  logic                tick, soft_clr;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_data   = result;
  assign tick        = (presc == PRESC_MAX);
  assign soft_clr    = (state == EXEC) && (op == OP_SOFT_RESET);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (instr_valid) state_nxt = EXEC;
      EXEC: state_nxt = (op == OP_MUL) ? MUL : RESP;
      MUL:  if (bit_idx == 2'd3) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:        alu = {4'b0, a} + {4'b0, b};
      OP_SUB:        alu = {4'b0, a} - {4'b0, b};
      OP_AND:        alu = {4'b0, a & b};
      OP_OR:         alu = {4'b0, a | b};
      OP_XOR:        alu = {4'b0, a ^ b};
      OP_SET_DUTY:   alu = {a, b};
      OP_SOFT_RESET: alu = RESET_RESP;
      default:       alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op      <= OP_ADD;
      a       <= '0;
      b       <= '0;
      bit_idx <= '0;
      result  <= '0;
      overrun <= 1'b0;
      duty    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        op <= op_t'(instr[10:8]);
        a  <= instr[7:4];
        b  <= instr[3:0];
      end
      if (state == EXEC) begin
        bit_idx <= '0;
        result  <= (op == OP_MUL) ? '0 : alu;
        if (op == OP_SET_DUTY)   duty <= PWM_BITS'({a, b});
        if (op == OP_SOFT_RESET) duty <= '0;
      end
      if (state == MUL) begin
        bit_idx <= bit_idx + 2'd1;
        if (b[bit_idx]) result <= result + ({4'b0, a} << bit_idx);
      end
      // Soft reset clear takes priority over a same-edge overrun set.
      if (soft_clr)                       overrun <= 1'b0;
      else if (instr_valid && !instr_ready) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      cnt         <= '0;
      duty_shadow <= '0;
      pwm_out     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt <= cnt + 1'b1;
        // Shadow reloads only as the counter wraps, so each period uses one duty.
        if (cnt == '1) duty_shadow <= duty;
      end
      if (soft_clr) duty_shadow <= '0;
      pwm_out <= (cnt < duty_shadow);
    end
  end

endmodule

// File: tb/tb_spi_alu_pwm.sv
// Bench for spi_alu_pwm: directed and random instructions against an arithmetic
// reference, plus edge-count based prediction of the PWM waveform.
module tb_spi_alu_pwm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [10:0] instr = '0;
  logic        instr_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        busy;
  logic        overrun;
  logic        pwm_out;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int duty_m = 0;
  logic exp_ovr = 1'b0;

  spi_alu_pwm #(.PWM_BITS(8), .PWM_DIV(1), .RESET_RESP(8'hFF)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .busy(busy), .overrun(overrun), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; with PWM_DIV=1 the PWM counter equals k mod 256.
  always @(posedge clk or negedge rst)
    if (!rst) k <= 0;
    else      k <= k + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic int model(input int op, input int a, input int b);
    case (op)
      0: return a + b;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * b;
      6: return a * 16 + b;
      default: return 255;
    endcase
  endfunction

  task automatic send(input int op, input int a, input int b, input int hold);
    int lat;
    logic [7:0] want;
    want = 8'(model(op, a, b));
    if (op == 7) exp_ovr = 1'b0;
    @(negedge clk);
    check("ready_idle", instr_ready, 1);
    instr = 11'(op * 256 + a * 16 + b);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      check("busy", busy, 1);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (op == 5) ? 6 : 2);
    check("resp", resp_data, want);
    check("overrun", overrun, exp_ovr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, want);
      check("hold_ready", instr_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done", resp_valid, 0);
    check("idle_after", instr_ready, 1);
    if (op == 6) duty_m = a * 16 + b;
    if (op == 7) duty_m = 0;
  endtask

  task automatic set_duty_checked(input int d);
    int old_d, bnd;
    old_d = duty_m;
    for (int i = 0; i < 600 && (k % 256) != 100; i++) @(negedge clk);
    send(6, d / 16, d % 16, 0);
    bnd = ((k / 256) + 1) * 256;
    while (k < bnd + 256) begin
      check("pwm", pwm_out, ((k - 1) % 256) < (((k - 1) >= bnd) ? d : old_d));
      @(negedge clk);
    end
  endtask

  initial begin
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_pwm", pwm_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    send(0, 7, 9, 3);
    send(1, 3, 5, 1);
    send(4, 10, 5, 2);
    send(5, 15, 15, 0);
    send(5, 0, 9, 1);
    send(0, 5, 6, 20);

    for (int t = 0; t < 40; t++)
      send(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    // Instruction offered in RESP together with resp_ready: response completes, instruction dropped.
    @(negedge clk);
    instr = {3'd0, 4'd3, 4'd4};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 12 && !resp_valid; i++) @(negedge clk);
    check("ovr_resp", resp_data, 7);
    instr = {3'd0, 4'd1, 4'd1};
    instr_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    resp_ready = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_done", resp_valid, 0);
    check("ovr_idle", instr_ready, 1);
    exp_ovr = 1'b1;
    send(0, 2, 2, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    instr = 11'b101_1111_1111;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("mul_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", instr_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_valid", resp_valid, 0);
    check("arst_data", resp_data, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_ovr", overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    duty_m = 0;
    exp_ovr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_resp", resp_valid, 0);
    end

    set_duty_checked(8'h40);
    set_duty_checked(0);
    set_duty_checked(8'hFF);

    exp_ovr = 1'b1;
    @(negedge clk);
    instr = {3'd0, 4'd1, 4'd1};
    instr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 12 && !resp_valid; i++) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("ovr_exec", overrun, 1);

    send(7, 0, 0, 1);
    check("soft_ovr", overrun, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("soft_pwm", pwm_out, 0);
    end
    set_duty_checked(8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
